// File: rtl/ripple_carry_counter.sv
// ripple_carry_counter: WIDTH-bit synchronous up-counter built from chained T stages.
// Define RCC_SATURATE_EN to hold at all ones instead of wrapping.
module ripple_carry_counter #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             rst
);
  logic [WIDTH-1:0] carry;
`ifdef RCC_SATURATE_EN
  assign carry[0] = ~&q;
`else
  assign carry[0] = 1'b1;
`endif
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = carry[i-1] & q[i-1];
  end
  // Each bit is a T flip-flop: toggle when every lower bit is set.
  always_ff @(posedge clk)
    q <= rst ? '0 : q ^ carry;
endmodule

// File: tb/tb_ripple_carry_counter.sv
// tb_ripple_carry_counter: random and directed checks of ripple_carry_counter against an arithmetic model.
module tb_ripple_carry_counter;
  localparam int WIDTH = 4;
  localparam int MAXV = (1 << WIDTH) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0] q;
  int tests = 0;
  int fails = 0;
  int exp_q = 0;
  ripple_carry_counter #(.WIDTH(WIDTH)) dut (.q(q), .clk(clk), .rst(rst));
  always #5 clk = ~clk;
  task automatic check(input string tag);
    tests++;
    assert (q === WIDTH'(exp_q))
    else begin
      fails++;
      $error("FAIL %s q=%0d expected %0d", tag, q, exp_q);
    end
  endtask
  task automatic step(input logic r, input string tag);
    rst = r;
    @(posedge clk);
    if (r) exp_q = 0;
`ifdef RCC_SATURATE_EN
    else exp_q = (exp_q == MAXV) ? MAXV : exp_q + 1;
`else
    else exp_q = (exp_q + 1) % (MAXV + 1);
`endif
    #1;
    check(tag);
  endtask
  initial begin
    step(1'b1, "reset_first");
    step(1'b1, "reset_hold");
    for (int i = 0; i < 10; i++) step(1'b0, "count_up");
    tests++;
    assert (q === WIDTH'(10))
    else begin
      fails++;
      $error("FAIL count_ten q=%0d expected 10", q);
    end
    step(1'b1, "reset_before_wrap");
    for (int i = 0; i < 20; i++) step(1'b0, "wrap_or_saturate");
    step(1'b1, "reset_mid");
    for (int i = 0; i < 9; i++) step(1'b0, "run_to_nine");
    step(1'b1, "reset_at_nine");
    step(1'b0, "release_one");
    for (int i = 0; i < 3; i++) step(1'b0, "pre_glitch");
    rst = 1'b1;
    #2;
    check("rst_between_edges");
    rst = 1'b0;
    step(1'b0, "after_glitch");
    for (int i = 0; i < 300; i++) step($urandom_range(0, 19) == 0, "random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
